alu_sequencer: RTL and testbench

Multi-cycle controller that owns one combinational 16-bit Hack-style ALU (control bits zx, nx, zy, ny, f, no; flags zr, ng) and sequences it on behalf of a single requester. It accepts an opcode and two operands over a valid/ready handshake and drives the ALU operand and control pins. Single-pass operations complete in one ALU pass. MUL is done as a 16-iteration shift-add loop that reuses the ALU adder. Result and flags are returned over a second valid/ready handshake.

---
 rtl/alu_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Multi-cycle controller for an external combinational 16-bit Hack-style ALU.
//   Accepts {op, a, b} over a valid/ready handshake, runs single-pass ops in
//   one ALU pass and MUL as a 16-iteration shift-add loop on the ALU adder,
//   then returns result and ALU flags over a second valid/ready handshake.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_op[2:0]             0 ADD,1 SUB,2 AND,3 OR,4 NEG,5 PASS,6 MUL,7 INC
//   req_a, req_b [15:0]     operands, captured at acceptance
//   rsp_valid/rsp_ready     response handshake
//   rsp_data[15:0]          result; rsp_zr / rsp_ng its zero / negative flags
//   alu_x, alu_y [15:0]     ALU operands
//   alu_ctl[5:0]            {zx,nx,zy,ny,f,no}
//   alu_o[15:0], alu_zr, alu_ng   ALU result and flags
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_zr,
  output logic        rsp_ng,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_ctl,
  input  logic [15:0] alu_o,
  input  logic        alu_zr,
  input  logic        alu_ng
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_MFLAG,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_NEG  = 3'd4,
    OP_PASS = 3'd5,
    OP_MUL  = 3'd6,
    OP_INC  = 3'd7
  } op_t;

  localparam logic [5:0] CTL_ADD  = 6'b000010;
  localparam logic [5:0] CTL_SUB  = 6'b010011;
  localparam logic [5:0] CTL_AND  = 6'b000000;
  localparam logic [5:0] CTL_OR   = 6'b010101;
  localparam logic [5:0] CTL_NEG  = 6'b001111;
  localparam logic [5:0] CTL_PASS = 6'b001100;
  localparam logic [5:0] CTL_INC  = 6'b011111;

  state_t      state, state_next;
  op_t         op_r;
  logic [15:0] a_r, b_r;
  logic [15:0] acc, mcand, mplier;
  logic [3:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_r     <= OP_ADD;
      a_r      <= '0;
      b_r      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_zr   <= 1'b0;
      rsp_ng   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_r <= op_t'(req_op);
            a_r  <= req_a;
            b_r  <= req_b;
            if (req_op == OP_MUL) begin
              acc    <= '0;
              mcand  <= req_a;
              mplier <= req_b;
              cnt    <= '0;
            end
          end
        end
        S_EXEC, S_MFLAG: begin
          rsp_data <= alu_o;
          rsp_zr   <= alu_zr;
          rsp_ng   <= alu_ng;
        end
        S_MUL: begin
          // ALU is computing acc + mcand; keep it only for set multiplier bits
          if (mplier[0]) acc <= alu_o;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    alu_x      = '0;
    alu_y      = '0;
    alu_ctl    = '0;
    case (state)
      S_IDLE: begin
        if (req_valid) state_next = (req_op == OP_MUL) ? S_MUL : S_EXEC;
      end
      S_EXEC: begin
        alu_x = a_r;
        alu_y = b_r;
        case (op_r)
          OP_ADD:  alu_ctl = CTL_ADD;
          OP_SUB:  alu_ctl = CTL_SUB;
          OP_AND:  alu_ctl = CTL_AND;
          OP_OR:   alu_ctl = CTL_OR;
          OP_NEG:  alu_ctl = CTL_NEG;
          OP_PASS: alu_ctl = CTL_PASS;
          OP_INC:  alu_ctl = CTL_INC;
          default: alu_ctl = CTL_ADD;
        endcase
        state_next = S_DONE;
      end
      S_MUL: begin
        alu_x   = acc;
        alu_y   = mcand;
        alu_ctl = CTL_ADD;
        if (cnt == 4'd15) state_next = S_MFLAG;
      end
      S_MFLAG: begin
        // extra pass so the product's flags come from the ALU itself
        alu_x      = acc;
        alu_ctl    = CTL_PASS;
        state_next = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Self-checking bench for alu_sequencer. Provides a behavioural Hack ALU on
//   the alu_* pins, issues directed and random requests, pushes expected
//   results (plain arithmetic reference) into a scoreboard queue, and a
//   monitor compares each fresh response, including its latency.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        rsp_zr, rsp_ng;
  logic [15:0] alu_x, alu_y;
  logic [5:0]  alu_ctl;
  logic [15:0] alu_o;
  logic        alu_zr, alu_ng;

  alu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zr    (rsp_zr),
    .rsp_ng    (rsp_ng),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_ctl   (alu_ctl),
    .alu_o     (alu_o),
    .alu_zr    (alu_zr),
    .alu_ng    (alu_ng)
  );

  always #5 clk = ~clk;

  // Hack ALU: zx, nx, zy, ny, f, no
  logic [15:0] hx, hy, ho;
  always_comb begin
    hx = alu_ctl[5] ? 16'h0000 : alu_x;
    hx = alu_ctl[4] ? ~hx : hx;
    hy = alu_ctl[3] ? 16'h0000 : alu_y;
    hy = alu_ctl[2] ? ~hy : hy;
    ho = alu_ctl[1] ? (hx + hy) : (hx & hy);
    ho = alu_ctl[0] ? ~ho : ho;
    alu_o  = ho;
    alu_zr = (ho == 16'h0000);
    alu_ng = ho[15];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
    logic [31:0] p;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return 16'h0000 - a;
      3'd5: return a;
      3'd6: begin p = {16'h0000, a} * {16'h0000, b}; return p[15:0]; end
      default: return a + 16'h0001;
    endcase
  endfunction

  typedef struct {
    logic [15:0] data;
    logic        zr;
    logic        ng;
    int unsigned edge_no;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];

  // monitor: compare on the first cycle a response is presented
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (rsp_valid && !prev_v) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_rsp: got data %0h expected no response", rsp_data);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", {16'h0, rsp_data}, {16'h0, e.data});
          chk("rsp_zr", {31'h0, rsp_zr}, {31'h0, e.zr});
          chk("rsp_ng", {31'h0, rsp_ng}, {31'h0, e.ng});
          chk("rsp_latency", cyc - e.edge_no, e.lat);
        end
      end
      prev_v = rsp_valid;
    end
  end

  logic        armed = 1'b0;
  int unsigned prev_edge = 0;
  int unsigned prev_lat = 0;

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [15:0] r;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      checks++;
      $display("FAIL accept_timeout: req_ready 0 expected 1 within 100 cycles");
      req_valid = 1'b0;
      return;
    end
    r = ref_result(op, a, b);
    e.data = r;
    e.zr = (r == 16'h0000);
    e.ng = r[15];
    e.edge_no = cyc + 1;
    e.lat = (op == 3'd6) ? 17 : 1;
    sb.push_back(e);
    if (armed) chk("issue_spacing", e.edge_no - prev_edge, prev_lat + 2);
    armed = 1'b1;
    prev_edge = e.edge_no;
    prev_lat = e.lat;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 3'($urandom);
    req_a = 16'($urandom);
    req_b = 16'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (sb.size() != 0 || rsp_valid); i++) @(negedge clk);
    if (sb.size() != 0 || rsp_valid) begin
      checks++;
      $display("FAIL drain_timeout: %0d responses outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"}, {16'h0, rsp_data}, 32'd0);
    chk({tag, "_rsp_flags"}, {30'h0, rsp_zr, rsp_ng}, 32'd0);
    chk({tag, "_alu_x"}, {16'h0, alu_x}, 32'd0);
    chk({tag, "_alu_y"}, {16'h0, alu_y}, 32'd0);
    chk({tag, "_alu_ctl"}, {26'h0, alu_ctl}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bp_exp;
    logic [2:0]  rop;
    #1;
    chk_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // directed, back-to-back
    issue(3'd0, 16'h7FFF, 16'h0001);
    issue(3'd1, 16'h0005, 16'h0005);
    issue(3'd4, 16'h0001, 16'h0000);
    issue(3'd7, 16'hFFFF, 16'h0000);
    issue(3'd2, 16'hF0F0, 16'h3C3C);
    issue(3'd3, 16'hF0F0, 16'h3C3C);
    issue(3'd5, 16'h8001, 16'h1111);
    issue(3'd6, 16'h0123, 16'h0045);
    issue(3'd6, 16'hFFFF, 16'hFFFF);
    issue(3'd6, 16'h1234, 16'h0000);
    issue(3'd0, 16'h0001, 16'h0001);
    drain();
    armed = 1'b0;

    // back-pressure
    rsp_ready = 1'b0;
    issue(3'd3, 16'h1234, 16'h00F0);
    armed = 1'b0;
    bp_exp = ref_result(3'd3, 16'h1234, 16'h00F0);
    for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'd1);
      chk("bp_rsp_data", {16'h0, rsp_data}, {16'h0, bp_exp});
      chk("bp_flags", {30'h0, rsp_zr, rsp_ng}, {30'h0, bp_exp == 16'h0, bp_exp[15]});
      chk("bp_req_ready", {31'h0, req_ready}, 32'd0);
      if (i == 2) begin
        req_valid = 1'b1;
        req_op = 3'd0;
        req_a = 16'h0101;
        req_b = 16'h0202;
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (25) @(negedge clk);
    chk("bp_idle_req_ready", {31'h0, req_ready}, 32'd1);
    drain();

    // reset in the middle of a MUL
    issue(3'd6, 16'h00FF, 16'h0F0F);
    armed = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_mul_rst");
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd0, 16'h0002, 16'h0003);
    drain();
    armed = 1'b0;
    repeat (20) @(negedge clk);

    // random back-to-back
    for (int i = 0; i < 8; i++) begin
      rop = (i == 2 || i == 5) ? 3'd6 : 3'($urandom_range(0, 7));
      issue(rop, 16'($urandom), 16'($urandom));
    end
    drain();
    armed = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
